uart_tx_feeder: RTL
===================

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter DATA_W, default 8, meaning byte width and the transmitter's tx_in width.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port wr_en  input  1  write strobe from the producer.
REQ-006 SHALL have port wr_data  input  DATA_W  byte to queue.
REQ-007 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-008 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-009 SHALL have port overflow  output  1  sticky flag: a write was dropped.
REQ-010 SHALL have port send  output  1  start request to the UART transmitter.
REQ-011 SHALL have port tx_in  output  DATA_W  byte presented to the transmitter.
REQ-012 SHALL have port tx_done  input  1  transmitter frame-complete flag, held high for about one bit period.
REQ-013 SHALL have port busy  output  1  FSM not in IDLE.

Function
REQ-014 SHALL accept a write when wr_en=1 and full=0, as sampled at the same edge; level increments.
REQ-015 SHALL drop a write when wr_en=1 and full=1, setting overflow=1 until reset, with FIFO contents unchanged.
REQ-016 SHALL apply pop-only, write-only and simultaneous write+pop together in one cycle: simultaneous leaves level unchanged; no write-to-read bypass.
REQ-017 SHALL wrap read and write pointers modulo DEPTH; full = (level==DEPTH); empty = (level==0).
REQ-018 SHALL implement FSM states IDLE, SEND and WAIT_LOW.
REQ-019 IDLE: if FIFO is non-empty at an edge, SHALL pop the head, register it to tx_in, set send=1 and enter SEND at that edge.
REQ-020 Latency: a byte written at edge N into an empty FIFO with FSM in IDLE SHALL produce send=1 after edge N+1.
REQ-021 SEND: SHALL hold send=1 and tx_in stable until a tx_done rising edge, detected with a registered copy of tx_done.
REQ-022 On that rising edge, SHALL set send=0 and enter WAIT_LOW.
REQ-023 SHALL not treat a tx_done already high on entry to SEND as completion.
REQ-024 WAIT_LOW: SHALL stay until tx_done=0, then enter IDLE.
REQ-025 tx_in SHALL change only on a pop (IDLE->SEND).
REQ-026 busy SHALL be high in SEND and WAIT_LOW.
REQ-027 wr_en values other than those in REQ-014/015 SHALL have no effect; X-free outputs after reset.

Reset
REQ-028 With rst=0 at an edge, SHALL set FSM=IDLE, pointers=0, level=0, full=0, overflow=0, send=0, tx_in=0, busy=0, and tx_done history=0.
REQ-029 Reset mid-frame SHALL discard queued bytes and drop send at the same edge; writes during reset are ignored.

Structure
REQ-030 SHALL place the FSM state enum (IDLE/SEND/WAIT_LOW) and DATA_W default in shared package uart_pkg.
REQ-031 SHALL implement storage as one sub-module sync_fifo (parameters DEPTH, DATA_W; ports clk, rst, wr_en, wr_data, rd_en, rd_data, full, empty, level).
REQ-032 sync_fifo rd_data SHALL be the current head combinationally (first-word-fall-through) so the pop edge registers the correct byte.

Verification
REQ-033 Single byte: write 0xA5 into an empty FIFO -> send=1 and tx_in=0xA5 one cycle later; the bench model pulses tx_done -> send=0; IDLE after tx_done falls.
REQ-034 Burst: write 0x01..0x05 back-to-back -> tx_in sequence 0x01..0x05, exactly five send assertions, level returns to 0.
REQ-035 Full/overflow with DEPTH=16: hold the transmitter (no tx_done) and write 18 bytes -> first byte in SEND; FIFO holds 16 with full=1 after the 17th write; 18th write dropped, overflow=1.
REQ-036 Stale tx_done: tx_done already high when SEND is entered -> send stays 1 until tx_done falls and rises again.
REQ-037 Simultaneous write+pop at level=1 -> level stays 1; data order preserved.
REQ-038 Reset mid-SEND with 3 queued bytes -> next edge has send=0, level=0, busy=0; no further send without new writes.

Source files
------------

// File: rtl/uart_pkg.sv
// ------------------------------------------------------------------
// uart_pkg : shared types and defaults for the UART TX feeder
// Rev 1.0  : initial release
// ------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_LOW = 2'd2
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ------------------------------------------------------------------
// sync_fifo : single-clock FIFO with first-word-fall-through read data
// Rev 1.0   : initial release
// ------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_full_level = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              w_push;
  logic              w_pop;

  assign full    = (r_level == c_full_level);
  assign empty   = (r_level == '0);
  assign level   = r_level;
  assign rd_data = r_mem[r_rd_ptr];
  assign w_push  = wr_en && !full;
  assign w_pop   = rd_en && !empty;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_feeder.sv
// ------------------------------------------------------------------
// uart_tx_feeder : queues bytes and hands them one at a time to a UART TX
// Rev 1.0        : initial release
// ------------------------------------------------------------------
`default_nettype none

module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   send,
  output logic [DATA_W-1:0]      tx_in,
  input  logic                   tx_done,
  output logic                   busy
);

  tx_state_e          r_state;
  logic               r_send;
  logic [DATA_W-1:0]  r_tx_in;
  logic               r_overflow;
  logic               r_tx_done_q;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic [DATA_W-1:0]  w_rd_data;
  logic [$clog2(DEPTH):0] w_level;

  assign w_pop = (r_state == IDLE) && !w_empty;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .level   (w_level)
  );

  // Completion is a tx_done rising edge only, so a level left high from a
  // previous frame never ends the current one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_send      <= 1'b0;
      r_tx_in     <= '0;
      r_overflow  <= 1'b0;
      r_tx_done_q <= 1'b0;
    end else begin
      r_tx_done_q <= tx_done;
      if (wr_en && w_full) r_overflow <= 1'b1;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_tx_in <= w_rd_data;
            r_send  <= 1'b1;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (tx_done && !r_tx_done_q) begin
            r_send  <= 1'b0;
            r_state <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!tx_done) r_state <= IDLE;
        end
        default: begin
          r_send  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign full     = w_full;
  assign level    = w_level;
  assign overflow = r_overflow;
  assign send     = r_send;
  assign tx_in    = r_tx_in;
  assign busy     = (r_state != IDLE);

endmodule

`default_nettype wire
